// File: rtl/clefia_diffusion_engine.sv
// Iterative CLEFIA diffusion engine: one 32-bit word per cycle through M0 (or M1) over GF(2^8).
// Define CLEFIA_DIFF_M1_EN to let in_mode select M1; otherwise in_mode is ignored and M0 is always used.
module clefia_diffusion_engine #(
    parameter int NUM_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [32*NUM_WORDS-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [32*NUM_WORDS-1:0] out_data,
    output logic                    busy
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; the source
    // holds valid and data stable until that edge, and the result stays held until taken.
    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   work [NUM_WORDS];
    logic [31:0]   cur_word;
    logic [31:0]   new_word;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [31:0] mul_m0(input logic [31:0] w);
        logic [7:0] s  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x6 [4];
        for (int k = 0; k < 4; k++) begin
            s[k]  = w[31-8*k -: 8];
            x2[k] = xt(s[k]);
            x4[k] = xt(x2[k]);
            x6[k] = x4[k] ^ x2[k];
        end
        return {s[0]  ^ x2[1] ^ x4[2] ^ x6[3],
                x2[0] ^ s[1]  ^ x6[2] ^ x4[3],
                x4[0] ^ x6[1] ^ s[2]  ^ x2[3],
                x6[0] ^ x4[1] ^ x2[2] ^ s[3]};
    endfunction

`ifdef CLEFIA_DIFF_M1_EN
    logic mode_q;

    function automatic logic [31:0] mul_m1(input logic [31:0] w);
        logic [7:0] s  [4];
        logic [7:0] x2 [4];
        logic [7:0] x8 [4];
        logic [7:0] xa [4];
        for (int k = 0; k < 4; k++) begin
            s[k]  = w[31-8*k -: 8];
            x2[k] = xt(s[k]);
            x8[k] = xt(xt(x2[k]));
            xa[k] = x8[k] ^ x2[k];
        end
        return {s[0]  ^ x8[1] ^ x2[2] ^ xa[3],
                x8[0] ^ s[1]  ^ xa[2] ^ x2[3],
                x2[0] ^ xa[1] ^ s[2]  ^ x8[3],
                xa[0] ^ x2[1] ^ x8[2] ^ s[3]};
    endfunction

    assign new_word = mode_q ? mul_m1(cur_word) : mul_m0(cur_word);
`else
    logic unused_mode;
    assign unused_mode = in_mode;
    assign new_word    = mul_m0(cur_word);
`endif

    always_comb begin
        cur_word = work[0];
        for (int i = 1; i < NUM_WORDS; i++) begin
            if (cnt == CW'(i)) cur_word = work[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)      state_nx = BUSY;
            BUSY:    if (cnt == LAST)   state_nx = DONE;
            DONE:    if (out_ready)     state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < NUM_WORDS; i++) work[i] <= '0;
`ifdef CLEFIA_DIFF_M1_EN
            mode_q <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            cnt <= '0;
            for (int i = 0; i < NUM_WORDS; i++) work[i] <= in_data[32*i +: 32];
`ifdef CLEFIA_DIFF_M1_EN
            mode_q <= in_mode;
`endif
        end else if (state == BUSY) begin
            // Each word is rewritten in place, so the work register doubles as the result.
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (cnt == CW'(i)) work[i] <= new_word;
            end
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_out
        assign out_data[32*g +: 32] = (state == DONE) ? work[g] : 32'h0;
    end

endmodule

// File: tb/tb_clefia_diffusion_engine.sv
// Bench for clefia_diffusion_engine: directed vectors, random blocks against a GF(2^8) matrix model,
// back-pressure, mid-transaction reset and a single-word instance.
module tb_clefia_diffusion_engine;
    localparam int NW = 4;

`ifdef CLEFIA_DIFF_M1_EN
    localparam logic [31:0] E_M1_ONE  = 32'h0A020801;
    localparam logic [31:0] E_M1_BOTH = 32'h0B0A0A0B;
`else
    localparam logic [31:0] E_M1_ONE  = 32'h06040201;
    localparam logic [31:0] E_M1_BOTH = 32'h07060607;
`endif
    localparam logic [127:0] M0_ROWS = 128'h01020406_02010604_04060102_06040201;
    localparam logic [127:0] M1_ROWS = 128'h0108020A_08010A02_020A0108_0A020801;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic [32*NW-1:0] in_data, out_data;
    logic            rst1, in_valid1, in_ready1, in_mode1, out_valid1, out_ready1, busy1;
    logic [31:0]     in_data1, out_data1;

    clefia_diffusion_engine #(.NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    clefia_diffusion_engine #(.NUM_WORDS(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .in_mode(in_mode1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic         mode;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int bit_i = 14; bit_i >= 8; bit_i--) if (p[bit_i]) p ^= 15'h11D << (bit_i - 8);
        return p[7:0];
    endfunction

    function automatic logic [31:0] model_word(input logic mode, input logic [31:0] w);
        logic [127:0] rows;
        logic [7:0]   y;
        logic [31:0]  r;
`ifdef CLEFIA_DIFF_M1_EN
        rows = mode ? M1_ROWS : M0_ROWS;
`else
        rows = M0_ROWS;
`endif
        r = '0;
        for (int j = 0; j < 4; j++) begin
            y = '0;
            for (int k = 0; k < 4; k++)
                y ^= gf_mul(rows[127 - 8*(4*j+k) -: 8], w[31 - 8*k -: 8]);
            r[31 - 8*j -: 8] = y;
        end
        return r;
    endfunction

    function automatic logic [127:0] model_block(input logic mode, input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < NW; i++) r[32*i +: 32] = model_word(mode, d[32*i +: 32]);
        return r;
    endfunction

    // Caller leaves the DUT in IDLE; times are #1 after a rising edge.
    task automatic run_block(input logic mode, input logic [127:0] data, input logic [127:0] exp,
                             input int stall, input string tag);
        int           lat;
        logic         stable;
        logic [127:0] held;
        check({tag, " in_ready idle"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1; in_data = data; in_mode = mode;
        @(posedge clk); #1;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_mode  = ~mode;
        check({tag, " busy"}, 128'(busy), 128'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(NW));
        check({tag, " data"}, out_data, exp);
        held = out_data;
        stable = 1'b1;
        in_valid = 1'b1;
        repeat (stall) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== held || in_ready) stable = 1'b0;
        end
        check({tag, " stall stable"}, 128'(stable), 128'd1);
        check({tag, " in_ready done"}, 128'(in_ready), 128'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid after"}, 128'(out_valid), 128'd0);
        check({tag, " in_ready after"}, 128'(in_ready), 128'd1);
    endtask

    task automatic run_one(input logic mode, input logic [31:0] w, input logic [31:0] exp,
                           input string tag);
        int lat;
        in_valid1 = 1'b1; in_data1 = w; in_mode1 = mode;
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_data1 = $urandom; in_mode1 = ~mode;
        check({tag, " busy"}, 128'(busy1), 128'd1);
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'd1);
        check({tag, " data"}, 128'(out_data1), 128'(exp));
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check({tag, " in_ready after"}, 128'(in_ready1), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         mode;
        logic [127:0] data;
        logic         quiet;

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_mode1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

        vecs[0] = '{1'b0, {32'h80000000, 32'h01000001, 32'h00000001, 32'h00000000},
                          {32'h801D3A27, 32'h07060607, 32'h06040201, 32'h00000000}};
        vecs[1] = '{1'b1, {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001},
                          {32'h00000000, 32'h00000000, 32'h00000000, E_M1_ONE}};
        vecs[2] = '{1'b0, {4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}};
        vecs[3] = '{1'b1, {32'h01000001, 32'h00000000, 32'h01000001, 32'h00000000},
                          {E_M1_BOTH, 32'h00000000, E_M1_BOTH, 32'h00000000}};
        vecs[4] = '{1'b0, {32'h00000001, 32'h01000001, 32'h80000000, 32'h00000001},
                          {32'h06040201, 32'h07060607, 32'h801D3A27, 32'h06040201}};

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset out_data", out_data, 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset1 in_ready", 128'(in_ready1), 128'd1);
        rst = 1'b0; rst1 = 1'b0;

        for (int i = 0; i < 5; i++)
            run_block(vecs[i].mode, vecs[i].data, vecs[i].exp, 0, $sformatf("vec%0d", i));

        run_block(1'b0, vecs[0].data, vecs[0].exp, 10, "backpressure");

        for (int i = 0; i < 20; i++) begin
            mode = 1'($urandom_range(0, 1));
            data = {$urandom, $urandom, $urandom, $urandom};
            run_block(mode, data, model_block(mode, data), int'($urandom_range(0, 3)),
                      $sformatf("rand%0d", i));
        end

        // Abort in BUSY once two words are done.
        in_valid = 1'b1; in_data = vecs[4].data; in_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort out_valid", 128'(out_valid), 128'd0);
        check("abort out_data", out_data, 128'd0);
        check("abort in_ready", 128'(in_ready), 128'd1);
        check("abort busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid || busy) quiet = 1'b0;
        end
        check("abort nothing emitted", 128'(quiet), 128'd1);
        run_block(1'b0, vecs[0].data, vecs[0].exp, 1, "after abort");

        run_one(1'b0, 32'h00000001, 32'h06040201, "nw1 one");
        run_one(1'b0, 32'h01000001, 32'h07060607, "nw1 pair");
        run_one(1'b0, 32'h80000000, 32'h801D3A27, "nw1 reduce");
        run_one(1'b1, 32'h00000001, E_M1_ONE, "nw1 mode1");
        for (int i = 0; i < 5; i++) begin
            mode = 1'($urandom_range(0, 1));
            data[31:0] = $urandom;
            run_one(mode, data[31:0], model_word(mode, data[31:0]), $sformatf("nw1 rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/clefia_diffusion_engine.md
# clefia_diffusion_engine

Iterative CLEFIA diffusion engine: accepts a block of NUM_WORDS 32-bit words with a valid/ready handshake and multiplies each word by the CLEFIA diffusion matrix M0 or M1, one word per cycle, over GF(2^8). It presents the transformed block on a held output with valid/ready back-pressure. It replaces the fixed single-word combinational M0 stage in the F-function datapath, so F0 and F1 rounds share one matrix core and multi-word key-schedule blocks can be batched.

## Interface
- NUM_WORDS, default 4: words per transaction, legal range 1..8.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input block valid.
- in_ready  output  1  high only in IDLE.
- in_mode  input  1  0 = M0, 1 = M1; sampled at acceptance.
- in_data  input  32*NUM_WORDS  word i = in_data[32*i+31:32*i].
- out_valid  output  1  result block valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32*NUM_WORDS  result block, same word layout as in_data.
- busy  output  1  high in BUSY and DONE.

## Operation
- Word byte order: s0 = bits[31:24], s3 = bits[7:0]; y0..y3 use the same order.
- Field: GF(2^8), polynomial x^8+x^4+x^3+x^2+1 (0x11D); xtime(a) = (a<<1) ^ (a[7] ? 0x1D : 0), with the result truncated to 8 bits.
- M0 rows: [1,2,4,6] [2,1,6,4] [4,6,1,2] [6,4,2,1].
- M1 rows: [1,8,2,A] [8,1,A,2] [2,A,1,8] [A,2,8,1].
- Output byte: yj = XOR over k of M[j][k]*sk.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY on in_valid && in_ready. On that edge: in_data captured into a work register, in_mode latched, word counter set to 0.
- BUSY: each cycle, word[cnt] is transformed and written in place; cnt increments. On the edge where cnt == NUM_WORDS-1, cnt returns to 0 and the state moves to DONE.
- DONE: out_valid = 1 and out_data = work register, both held stable until out_ready. On out_valid && out_ready, the state moves to IDLE.
- in_ready = (state == IDLE). There is no same-cycle turnaround: in_ready rises the cycle after the output handshake.
- Changes to in_data and in_mode after acceptance have no effect on the transaction in progress.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, busy 0, cnt 0, latched mode 0.
- Latency: acceptance at edge E0 gives out_valid high after edge E_NUM_WORDS, i.e. NUM_WORDS cycles later.
- Minimum initiation interval: NUM_WORDS + 2 cycles (BUSY for NUM_WORDS cycles, at least one DONE cycle, one IDLE cycle).
- Combinational depth per cycle: one matrix row set, at most three xtime levels plus a 4-input XOR per output byte.
- Reset asserted mid-transaction (BUSY or DONE): the transaction is aborted and all registers return to reset values immediately. Nothing is emitted after rst deasserts.
- Reset deassertion is synchronised externally. The first acceptance is possible on the first clk edge with rst low.
- NUM_WORDS = 1: BUSY lasts exactly one cycle.

## Configuration
- CLEFIA_DIFF_M1_EN defined: in_mode selects M0 or M1 as described.
- CLEFIA_DIFF_M1_EN undefined: the M1 logic is not instantiated and in_mode is ignored; every transaction uses M0. Timing and handshake are unchanged.

## Test plan
- NUM_WORDS=1, mode 0, word 0x00000001 -> 0x06040201 after 1 cycle. Mode 0, word 0x01000001 -> 0x07060607.
- Reduction check: mode 0, word 0x80000000 -> 0x801D3A27. With M1 enabled, mode 1, word 0x00000001 -> 0x0A020801.
- NUM_WORDS=4, block {w3..w0} = {0x80000000, 0x01000001, 0x00000001, 0x00000000}, mode 0 -> {0x801D3A27, 0x07060607, 0x06040201, 0x00000000}. out_valid exactly 4 cycles after acceptance.
- Back-pressure: hold out_ready low for 10 cycles in DONE -> out_data and out_valid stable, in_ready 0. Release -> handshake, then in_ready 1 on the next cycle.
- Reset asserted in BUSY with cnt = 2 -> out_valid 0, out_data 0, in_ready 1 immediately. The next accepted block produces correct results.
- Macro undefined: mode 1 with 0x00000001 -> 0x06040201 (M0 result).
